// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Brief    : Shared widths and data-memory arbiter state encodings.
// Revision : 1.0
// ============================================================================
package mips_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 32;
    localparam int LAT_W      = 4;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_BUSY_CPU = 2'd1,
        ARB_BUSY_DBG = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/arb_lat_counter.sv
`default_nettype none
// ============================================================================
// Module   : arb_lat_counter
// Brief    : Loadable down-counter timing one memory access; flags zero.
// Revision : 1.0
// ============================================================================
module arb_lat_counter
    import mips_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [LAT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [LAT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Shares the data memory between the CPU MEM stage and a debug port.
// Revision : 1.0
// ============================================================================
module dmem_arbiter
    import mips_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk_ARB,
    input  logic              rst_ARB,
    input  logic [ADDR_W-1:0] cpuAddr,
    input  logic [DATA_W-1:0] cpuWrData,
    input  logic              cpuRead,
    input  logic              cpuWrite,
    output logic [DATA_W-1:0] cpuRdData,
    output logic              cpuDone,
    output logic              cpuStall,
    input  logic              dbgValid,
    input  logic              dbgWrite,
    input  logic [ADDR_W-1:0] dbgAddr,
    input  logic [DATA_W-1:0] dbgWrData,
    output logic              dbgReady,
    output logic [DATA_W-1:0] dbgRdData,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memData,
    output logic              memReadFlag,
    output logic              memWriteFlag,
    input  logic [DATA_W-1:0] memRdData
);

    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT - 1);
    localparam int STARVE_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    arb_state_t          state, state_nxt;
    logic                cpu_req, dbg_req;
    logic                grant_cpu, grant_dbg, finish;
    logic                lat_zero;
    logic [STARVE_W-1:0] starve_cnt;

    // Masking with the done pulses keeps a retiring request from being re-granted.
    assign cpu_req  = (cpuRead | cpuWrite) & ~cpuDone;
    assign dbg_req  = dbgValid & ~dbgReady;
    assign cpuStall = cpu_req & ~rst_ARB;

    always_ff @(posedge clk_ARB or posedge rst_ARB) begin
        if (rst_ARB) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_cpu = 1'b0;
        grant_dbg = 1'b0;
        finish    = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (cpu_req && (!dbg_req || (starve_cnt < STARVE_LIM))) begin
                    grant_cpu = 1'b1;
                    state_nxt = ARB_BUSY_CPU;
                end else if (dbg_req) begin
                    grant_dbg = 1'b1;
                    state_nxt = ARB_BUSY_DBG;
                end
            end
            ARB_BUSY_CPU, ARB_BUSY_DBG: begin
                if (lat_zero) begin
                    finish    = 1'b1;
                    state_nxt = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    arb_lat_counter u_lat (
        .clk      (clk_ARB),
        .rst      (rst_ARB),
        .load     (grant_cpu | grant_dbg),
        .load_val (LAT_LOAD),
        .dec      ((state != ARB_IDLE) && !lat_zero),
        .zero     (lat_zero)
    );

    always_ff @(posedge clk_ARB or posedge rst_ARB) begin
        if (rst_ARB) begin
            memAddr      <= '0;
            memData      <= '0;
            memReadFlag  <= 1'b0;
            memWriteFlag <= 1'b0;
            cpuRdData    <= '0;
            dbgRdData    <= '0;
            cpuDone      <= 1'b0;
            dbgReady     <= 1'b0;
        end else begin
            cpuDone  <= 1'b0;
            dbgReady <= 1'b0;
            if (grant_cpu) begin
                // A simultaneous read+write request is executed as a write.
                memAddr      <= cpuAddr;
                memData      <= cpuWrData;
                memWriteFlag <= cpuWrite;
                memReadFlag  <= cpuRead & ~cpuWrite;
            end else if (grant_dbg) begin
                memAddr      <= dbgAddr;
                memData      <= dbgWrData;
                memWriteFlag <= dbgWrite;
                memReadFlag  <= ~dbgWrite;
            end
            if (finish) begin
                memReadFlag  <= 1'b0;
                memWriteFlag <= 1'b0;
                if (state == ARB_BUSY_CPU) begin
                    cpuRdData <= memRdData;
                    cpuDone   <= 1'b1;
                end else begin
                    dbgRdData <= memRdData;
                    dbgReady  <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_ARB or posedge rst_ARB) begin
        if (rst_ARB) begin
            starve_cnt <= '0;
        end else if (!dbg_req || grant_dbg) begin
            starve_cnt <= '0;
        end else if (grant_cpu && (starve_cnt < STARVE_LIM)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire
